// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM elastic stage: default widths, entry layout, occupancy encoding.
package pipe_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int DEST_W_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // Default-width layout; the top re-declares the same field order at its own parameter widths.
    typedef struct packed {
        logic                  rmem;
        logic                  wmem;
        logic                  wreg;
        logic                  vf;
        logic [DEST_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] alures;
        logic [DATA_W_DEF-1:0] store;
    } ex_mem_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic register (main M drives outputs, skid S catches one entry under stall); 1-cycle latency.
// in_ready is !S.valid from registered state only, so out_ready has no combinational path to in_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_dat
);

    occ_e         r_occ;
    logic [W-1:0] r_m;
    logic [W-1:0] r_s;
    logic         w_acc;
    logic         w_pop;

    assign in_ready  = (r_occ != TWO);
    assign out_valid = (r_occ != EMPTY);
    assign out_dat   = r_m;
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_occ <= EMPTY;
            r_m   <= '0;
            r_s   <= '0;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (w_acc) begin
                        r_m   <= in_dat;
                        r_occ <= ONE;
                    end
                end
                ONE: begin
                    if (w_acc && w_pop) begin
                        r_m <= in_dat;
                    end else if (w_acc) begin
                        r_s   <= in_dat;
                        r_occ <= TWO;
                    end else if (w_pop) begin
                        r_occ <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move state
                    if (w_pop) begin
                        r_m   <= r_s;
                        r_occ <= ONE;
                    end
                end
                default: r_occ <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ex_mem_elastic.sv
// EX/MEM valid/ready pipeline stage: packs EX fields into one entry, holds it in a 2-deep skid buffer.
// 1-cycle latency when empty or popping; MEM stall back-pressures EX after two entries are held.
module pipeline_ex_mem_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEST_W    = DEST_W_DEF,
    parameter bit GATE_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rmem,
    input  logic              in_wmem,
    input  logic              in_wreg,
    input  logic              in_vf,
    input  logic [DATA_W-1:0] in_alures,
    input  logic [DATA_W-1:0] in_store,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rmem,
    output logic              out_wmem,
    output logic              out_wreg,
    output logic              out_vf,
    output logic [DATA_W-1:0] out_alures,
    output logic [DATA_W-1:0] out_store,
    output logic [DEST_W-1:0] out_dest
);

    typedef struct packed {
        logic              rmem;
        logic              wmem;
        logic              wreg;
        logic              vf;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] store;
    } ex_mem_w_t;

    ex_mem_w_t w_in;
    ex_mem_w_t w_out;
    logic      w_ctrl_en;

    assign w_in.rmem   = in_rmem;
    assign w_in.wmem   = in_wmem;
    assign w_in.wreg   = in_wreg;
    assign w_in.vf     = in_vf;
    assign w_in.dest   = in_dest;
    assign w_in.alures = in_alures;
    assign w_in.store  = in_store;

    pipe_skid_buf #(
        .W ($bits(ex_mem_w_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (w_out)
    );

    // Side-effecting control bits are masked on bubbles so MEM never acts on a stale entry
    assign w_ctrl_en  = GATE_CTRL ? out_valid : 1'b1;
    assign out_rmem   = w_out.rmem & w_ctrl_en;
    assign out_wmem   = w_out.wmem & w_ctrl_en;
    assign out_wreg   = w_out.wreg & w_ctrl_en;
    assign out_vf     = w_out.vf;
    assign out_dest   = w_out.dest;
    assign out_alures = w_out.alures;
    assign out_store  = w_out.store;

endmodule

// File: tb/tb_pipeline_ex_mem_elastic.sv
// Bench: narrow gated instance and wide ungated instance share handshakes; vector table then random vs queue model.
module tb_pipeline_ex_mem_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, out_ready;
    logic         in_rmem, in_wmem, in_wreg, in_vf;
    logic [127:0] n_alu, n_store;
    logic [3:0]   n_dest;
    logic [255:0] w_alu, w_store;
    logic [4:0]   w_dest;

    logic         n_ir, n_ov, n_rm, n_wm, n_wr, n_vf;
    logic [127:0] n_oalu, n_ostore;
    logic [3:0]   n_odest;
    logic         w_ir, w_ov, w_rm, w_wm, w_wr, w_vf;
    logic [255:0] w_oalu, w_ostore;
    logic [4:0]   w_odest;

    pipeline_ex_mem_elastic u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
        .in_rmem(in_rmem), .in_wmem(in_wmem), .in_wreg(in_wreg), .in_vf(in_vf),
        .in_alures(n_alu), .in_store(n_store), .in_dest(n_dest),
        .out_valid(n_ov), .out_ready(out_ready),
        .out_rmem(n_rm), .out_wmem(n_wm), .out_wreg(n_wr), .out_vf(n_vf),
        .out_alures(n_oalu), .out_store(n_ostore), .out_dest(n_odest)
    );

    pipeline_ex_mem_elastic #(.DATA_W(256), .DEST_W(5), .GATE_CTRL(1'b0)) u_dut_w (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_ir),
        .in_rmem(in_rmem), .in_wmem(in_wmem), .in_wreg(in_wreg), .in_vf(in_vf),
        .in_alures(w_alu), .in_store(w_store), .in_dest(w_dest),
        .out_valid(w_ov), .out_ready(out_ready),
        .out_rmem(w_rm), .out_wmem(w_wm), .out_wreg(w_wr), .out_vf(w_vf),
        .out_alures(w_oalu), .out_store(w_ostore), .out_dest(w_odest)
    );

    typedef struct packed {
        logic         rmem;
        logic         wmem;
        logic         wreg;
        logic         vf;
        logic [4:0]   dest;
        logic [255:0] alu;
        logic [255:0] store;
    } ent_t;

    typedef struct {
        logic       rst, flush, iv, ordy;
        logic [7:0] a8;
        logic [3:0] d4;
        logic       wm, wr;
        logic       eov, eir;
        logic [7:0] ea8;
        logic [3:0] ed4;
        logic       ewm, ewr, ewmr, ewrr;
    } vec_t;

    vec_t tbl[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_alu(input logic [7:0] a);
        return (a == 8'h0) ? 256'h0 : {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 120'h0, a};
    endfunction

    function automatic logic [4:0] mk_dest(input logic [7:0] a, input logic [3:0] d);
        return (a == 8'h0) ? 5'h0 : {1'b1, d};
    endfunction

    task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [7:0] a8, input logic [3:0] d4, input logic wm, input logic wr,
                       input logic eov, input logic eir, input logic [7:0] ea8, input logic [3:0] ed4,
                       input logic ewm, input logic ewr, input logic ewmr, input logic ewrr);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.a8 = a8; v.d4 = d4; v.wm = wm; v.wr = wr;
        v.eov = eov; v.eir = eir; v.ea8 = ea8; v.ed4 = ed4;
        v.ewm = ewm; v.ewr = ewr; v.ewmr = ewmr; v.ewrr = ewrr;
        tbl.push_back(v);
    endtask

    task automatic drive(input ent_t e);
        in_rmem = e.rmem; in_wmem = e.wmem; in_wreg = e.wreg; in_vf = e.vf;
        w_alu = e.alu; w_store = e.store; w_dest = e.dest;
        n_alu = e.alu[127:0]; n_store = e.store[127:0]; n_dest = e.dest[3:0];
    endtask

    ent_t q[$];
    ent_t last, cur, head;
    bit   acc, pop;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cur = '0;
        drive(cur);

        //   rst f iv rdy a8    d4  wm wr | ov ir ea8   ed4 wm wr wmr wrr
        add(0, 0, 1, 1, 8'h55, 4'h5, 1, 1,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 8'h55, 4'h5, 1, 1,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 8'h01, 4'h1, 0, 1,  1, 1, 8'h01, 4'h1, 0, 1, 0, 1);
        add(1, 0, 1, 1, 8'h02, 4'h2, 0, 1,  1, 1, 8'h02, 4'h2, 0, 1, 0, 1);
        add(1, 0, 1, 1, 8'h03, 4'h3, 0, 1,  1, 1, 8'h03, 4'h3, 0, 1, 0, 1);
        add(1, 0, 1, 1, 8'h04, 4'hF, 0, 1,  1, 1, 8'h04, 4'hF, 0, 1, 0, 1);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'h04, 4'hF, 0, 0, 0, 1);
        add(1, 0, 1, 0, 8'hAA, 4'hA, 1, 0,  1, 1, 8'hAA, 4'hA, 1, 0, 1, 0);
        add(1, 0, 1, 0, 8'hBB, 4'hB, 0, 1,  1, 0, 8'hAA, 4'hA, 1, 0, 1, 0);
        add(1, 0, 1, 0, 8'hCC, 4'hC, 0, 0,  1, 0, 8'hAA, 4'hA, 1, 0, 1, 0);
        add(1, 0, 1, 1, 8'hCC, 4'hC, 0, 0,  1, 1, 8'hBB, 4'hB, 0, 1, 0, 1);
        add(1, 0, 1, 1, 8'hCC, 4'hC, 0, 0,  1, 1, 8'hCC, 4'hC, 0, 0, 0, 0);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'hCC, 4'hC, 0, 0, 0, 0);
        add(1, 0, 1, 0, 8'h11, 4'h1, 1, 1,  1, 1, 8'h11, 4'h1, 1, 1, 1, 1);
        add(1, 0, 1, 0, 8'h22, 4'h2, 0, 0,  1, 0, 8'h11, 4'h1, 1, 1, 1, 1);
        add(1, 1, 1, 1, 8'hDD, 4'hD, 1, 1,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 8'h5A, 4'h6, 1, 1,  1, 1, 8'h5A, 4'h6, 1, 1, 1, 1);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'h5A, 4'h6, 0, 0, 1, 1);
        add(1, 0, 1, 0, 8'h77, 4'h7, 0, 1,  1, 1, 8'h77, 4'h7, 0, 1, 0, 1);
        add(1, 0, 1, 0, 8'h88, 4'h8, 1, 0,  1, 0, 8'h77, 4'h7, 0, 1, 0, 1);
        add(0, 1, 1, 1, 8'h99, 4'h9, 1, 1,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 8'h00, 4'h0, 0, 0,  0, 1, 8'h00, 4'h0, 0, 0, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            cur.rmem = 1'b0; cur.vf = 1'b0; cur.wmem = tbl[i].wm; cur.wreg = tbl[i].wr;
            cur.alu = mk_alu(tbl[i].a8); cur.store = {32{tbl[i].a8}}; cur.dest = {1'b1, tbl[i].d4};
            drive(cur);
            @(posedge clk); #1;
            chk("out_valid", i, {255'h0, n_ov}, {255'h0, tbl[i].eov});
            chk("in_ready", i, {255'h0, n_ir}, {255'h0, tbl[i].eir});
            chk("alures", i, {128'h0, n_oalu}, {128'h0, mk_alu(tbl[i].ea8) & {128'h0, {128{1'b1}}}});
            chk("store", i, {128'h0, n_ostore}, {128'h0, {16{tbl[i].ea8}}});
            chk("dest", i, {252'h0, n_odest}, {252'h0, mk_dest(tbl[i].ea8, tbl[i].ed4) & 5'hF});
            chk("wmem_gated", i, {255'h0, n_wm}, {255'h0, tbl[i].ewm});
            chk("wreg_gated", i, {255'h0, n_wr}, {255'h0, tbl[i].ewr});
            chk("wide_valid", i, {255'h0, w_ov}, {255'h0, tbl[i].eov});
            chk("wide_alures", i, w_oalu, mk_alu(tbl[i].ea8));
            chk("wide_store", i, w_ostore, {32{tbl[i].ea8}});
            chk("wide_dest", i, {251'h0, w_odest}, {251'h0, mk_dest(tbl[i].ea8, tbl[i].ed4)});
            chk("wide_wmem_raw", i, {255'h0, w_wm}, {255'h0, tbl[i].ewmr});
            chk("wide_wreg_raw", i, {255'h0, w_wr}, {255'h0, tbl[i].ewrr});
        end

        // Random traffic against an ordered-queue model; starts from a reset cycle so model and DUT agree.
        q.delete();
        last = '0;
        for (int c = 0; c < 800; c++) begin
            rst       = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 8; k++) begin
                cur.alu[k*32 +: 32]   = $urandom;
                cur.store[k*32 +: 32] = $urandom;
            end
            cur.dest = 5'($urandom); cur.rmem = 1'($urandom); cur.wmem = 1'($urandom);
            cur.wreg = 1'($urandom); cur.vf = 1'($urandom);
            drive(cur);
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            @(posedge clk);
            if (!rst || flush) begin
                q.delete();
                last = '0;
            end else begin
                if (pop) last = q.pop_front();
                if (acc) q.push_back(cur);
            end
            #1;
            head = (q.size() > 0) ? q[0] : last;
            chk("rnd_out_valid", c, {255'h0, n_ov}, {255'h0, (q.size() > 0)});
            chk("rnd_in_ready", c, {255'h0, n_ir}, {255'h0, (q.size() < 2)});
            chk("rnd_alures", c, {128'h0, n_oalu}, {128'h0, head.alu[127:0]});
            chk("rnd_store", c, {128'h0, n_ostore}, {128'h0, head.store[127:0]});
            chk("rnd_dest", c, {252'h0, n_odest}, {252'h0, head.dest[3:0]});
            chk("rnd_ctrl_gated", c, {252'h0, n_rm, n_wm, n_wr, n_vf},
                {252'h0, head.rmem & (q.size() > 0), head.wmem & (q.size() > 0),
                 head.wreg & (q.size() > 0), head.vf});
            chk("rnd_wide_valid", c, {254'h0, w_ov, w_ir}, {254'h0, (q.size() > 0), (q.size() < 2)});
            chk("rnd_wide_alures", c, w_oalu, head.alu);
            chk("rnd_wide_store", c, w_ostore, head.store);
            chk("rnd_wide_ctrl_raw", c, {247'h0, w_odest, w_rm, w_wm, w_wr, w_vf},
                {247'h0, head.dest, head.rmem, head.wmem, head.wreg, head.vf});
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ex_mem_elastic.md
Name: pipeline_ex_mem_elastic

Overview:
Parametrised EX/MEM pipeline register for the vector datapath. It replaces the fixed 128-bit, always-advancing stage register with a valid/ready elastic stage. The stage has a two-entry skid buffer, synchronous flush, and bubble-gated control bits. It sits between the ALU/vector unit and the memory stage so a stalled memory stage can back-pressure EX without losing in-flight results.

Parameters:
DATA_W, 128, width of ALU result and store-data payloads (lanes x lane width).
DEST_W, 4, width of destination register/vector index.
GATE_CTRL, 1, when 1 the rmem/wmem/wreg outputs are forced 0 whenever out_valid=0.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
flush  in  1  discard all held entries (branch/exception kill).
in_valid  in  1  EX presents a valid instruction.
in_ready  out  1  stage can accept; transfer when in_valid&&in_ready.
in_rmem, in_wmem, in_wreg, in_vf  in  1 each  control bits from EX.
in_alures  in  DATA_W  ALU/vector result.
in_store  in  DATA_W  store data (R3/V3 operand).
in_dest  in  DEST_W  destination register index.
out_valid  out  1  MEM-side entry valid.
out_ready  in  1  MEM accepts; transfer when out_valid&&out_ready.
out_rmem, out_wmem, out_wreg, out_vf  out  1 each  registered control bits.
out_alures, out_store  out  DATA_W  registered payloads.
out_dest  out  DEST_W  registered destination.

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- Occupancy states: EMPTY (M,S invalid), ONE (M valid), TWO (M,S valid). S is never valid while M is invalid.
- in_ready = !S.valid. It is derived from registered state only and has no combinational path from out_ready.
- out_valid = M.valid. All out_* come directly from M.
- Transitions (acc = in_valid&&in_ready, pop = out_valid&&out_ready):
  - EMPTY: acc -> ONE, M<=in.
  - ONE, acc && pop -> ONE, M<=in.
  - ONE, acc && !pop -> TWO, S<=in.
  - ONE, !acc && pop -> EMPTY.
  - TWO, pop -> ONE, M<=S (acc impossible because in_ready=0).
  - TWO, !pop -> TWO, hold.
- Ordering: strict FIFO. No entry is duplicated or dropped.
- Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) when the stage is EMPTY, or when it is ONE with a simultaneous pop.
- Throughput: 1 entry/cycle while out_ready=1.
- Flush (rst high): at the next edge M.valid and S.valid are cleared and all payload/control flops are cleared to 0. Flush overrides a simultaneous acc or pop, so an entry offered in the flush cycle is discarded. in_ready=1 in the following cycle.
- Reset: when rst=0 at an edge, reset overrides flush and all handshakes. After that edge:
  - out_valid=0, all out_* = 0, in_ready=1, state EMPTY.
  - Reset asserted mid-transfer discards both entries.
- GATE_CTRL=1: out_rmem/out_wmem/out_wreg = stored bit AND M.valid. A bubble therefore never causes a memory access or register write.
- Payload fields are not gated; they hold their last value while invalid, except after flush or reset where they are 0.
- All widths are pass-through. No arithmetic is performed.

Decomposition:
- Package pipe_pkg holds:
  - localparams DATA_W_DEF=128 and DEST_W_DEF=4.
  - Parametrised struct typedef ex_mem_t {rmem, wmem, wreg, vf, dest, alures, store}.
  - Occupancy enum occ_e {EMPTY, ONE, TWO}.
- One natural sub-module: pipe_skid_buf.
  - Generic payload width W; implements M/S, the handshake and flush.
  - The top packs in_* into ex_mem_t, instantiates it with W=$bits(ex_mem_t), then unpacks and applies GATE_CTRL.

Test Plan:
1. Reset: hold rst=0 for 2 edges with in_valid=1 -> out_valid=0, out_* = 0, in_ready=1; first edge after release accepts nothing unless in_valid=1.
2. Streaming: out_ready=1; send in_alures=0x1..0x4 on consecutive cycles, dest=1..4 -> same values appear 1 cycle later, in order, out_valid high for 4 consecutive cycles.
3. Back-pressure: out_ready=0, push A=0xAA, B=0xBB -> in_ready drops after B, outputs hold A; C is not accepted. Raise out_ready -> A, then B, then C (offered again) delivered; nothing is lost or duplicated.
4. Flush in TWO with a simultaneous pop, plus in_valid with D=0xDD -> next cycle out_valid=0, payload 0, in_ready=1; D never appears.
5. Bubble gating: in_wmem=1, in_wreg=1 accepted, then popped with in_valid=0 -> after the pop out_wmem=out_wreg=0 (GATE_CTRL=1). With GATE_CTRL=0 the stored bits remain visible.
6. Parametrisation: DATA_W=256, DEST_W=5; rerun scenarios 2 and 3 with payload 0xFFFF...0001 and dest=31 -> upper bits are preserved end to end.
